// File: rtl/spu32_cpu_seqshifter_pkg.sv
// Shared definitions for the iterative shifter: FSM state encoding and the
// per-iteration step size. Build option: SPU32_SEQSHIFTER_STEP4_EN selects
// shift-by-4 iterations when enough distance remains.
package spu32_cpu_seqshifter_pkg;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_SHIFT = 1'b1
    } state_t;

`ifdef SPU32_SEQSHIFTER_STEP4_EN
    localparam int unsigned STEP_SIZE = 4;
`else
    localparam int unsigned STEP_SIZE = 1;
`endif

endpackage

// File: rtl/spu32_cpu_seqshifter_step.sv
// One iteration of the shifter datapath: shifts a word by 1 or by 4 positions,
// inserting zeros on the right for left shifts and the fill bit on the left
// for right shifts.
module spu32_cpu_seqshifter_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic            fill,
    input  logic            left,
    input  logic            by4,
    output logic [XLEN-1:0] result
);

    // Select the shifted word for the requested direction and distance.
    always_comb begin
        result = data;
        case ({left, by4})
            2'b00:   result = {fill, data[XLEN-1:1]};
            2'b01:   result = {{4{fill}}, data[XLEN-1:4]};
            2'b10:   result = {data[XLEN-2:0], 1'b0};
            2'b11:   result = {data[XLEN-5:0], 4'b0000};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/spu32_cpu_seqshifter.sv
// Multi-cycle iterative shift unit (SLL / SRL / SRA). A request is latched
// when idle; the working word is shifted one step per clock until the
// remaining distance reaches zero, then the result is published with a
// single-cycle O_ack. Build option: SPU32_SEQSHIFTER_STEP4_EN enables
// shift-by-4 steps while at least 4 positions remain.
module spu32_cpu_seqshifter
    import spu32_cpu_seqshifter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                     I_clk,
    input  logic                     I_reset,
    input  logic                     I_stb,
    input  logic [XLEN-1:0]          I_data,
    input  logic [$clog2(XLEN)-1:0]  I_shift,
    input  logic                     I_signextend,
    input  logic                     I_leftshift,
    output logic                     O_busy,
    output logic                     O_ack,
    output logic [XLEN-1:0]          O_data
);

    localparam int SHW = $clog2(XLEN);

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] work;
    logic [XLEN-1:0] work_stepped;
    logic [SHW-1:0]  count;
    logic [SHW-1:0]  step_amt;
    logic            left;
    logic            fill;
    logic            accept;
    logic            do_shift;
    logic            finish;
    logic            by4;

`ifdef SPU32_SEQSHIFTER_STEP4_EN
    assign by4 = (count >= SHW'(STEP_SIZE));
`else
    assign by4 = 1'b0;
`endif

    assign step_amt = by4 ? SHW'(STEP_SIZE) : SHW'(1);

    // Busy is a direct decode of the state register, so it rises the cycle
    // after acceptance and drops in the same cycle O_ack rises.
    assign O_busy = (state == STATE_SHIFT);

    spu32_cpu_seqshifter_step #(
        .XLEN(XLEN)
    ) u_step (
        .data   (work),
        .fill   (fill),
        .left   (left),
        .by4    (by4),
        .result (work_stepped)
    );

    // State register.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_shift   = 1'b0;
        finish     = 1'b0;
        case (state)
            STATE_IDLE: begin
                if (I_stb) begin
                    accept     = 1'b1;
                    state_next = STATE_SHIFT;
                end
            end
            STATE_SHIFT: begin
                if (count != '0) begin
                    do_shift = 1'b1;
                end else begin
                    finish     = 1'b1;
                    state_next = STATE_IDLE;
                end
            end
            default: state_next = STATE_IDLE;
        endcase
    end

    // Working register, distance counter, request latch and result output.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            work   <= '0;
            count  <= '0;
            left   <= 1'b0;
            fill   <= 1'b0;
            O_ack  <= 1'b0;
            O_data <= '0;
        end else begin
            O_ack <= finish;
            if (accept) begin
                work  <= I_data;
                count <= I_shift;
                left  <= I_leftshift;
                fill  <= I_signextend & ~I_leftshift & I_data[XLEN-1];
            end else if (do_shift) begin
                work  <= work_stepped;
                count <= count - step_amt;
            end
            if (finish) begin
                O_data <= work;
            end
        end
    end

endmodule

// File: tb/tb_spu32_cpu_seqshifter.sv
// Self-checking bench for spu32_cpu_seqshifter: directed cases followed by
// random operations, with expected result and latency queued at issue time
// and compared when O_ack appears. Honours SPU32_SEQSHIFTER_STEP4_EN.
module tb_spu32_cpu_seqshifter;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    typedef struct {
        logic [XLEN-1:0] data;
        int unsigned     lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            stb;
    logic [XLEN-1:0] din;
    logic [SHW-1:0]  shamt;
    logic            sext;
    logic            lsh;
    logic            busy;
    logic            ack;
    logic [XLEN-1:0] dout;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    spu32_cpu_seqshifter #(
        .XLEN(XLEN)
    ) dut (
        .I_clk        (clk),
        .I_reset      (rst),
        .I_stb        (stb),
        .I_data       (din),
        .I_shift      (shamt),
        .I_signextend (sext),
        .I_leftshift  (lsh),
        .O_busy       (busy),
        .O_ack        (ack),
        .O_data       (dout)
    );

    function automatic logic [XLEN-1:0] ref_shift(input logic [XLEN-1:0] d, input logic [SHW-1:0] n,
                                                  input logic se, input logic l);
        if (l)       return d << n;
        else if (se) return $unsigned($signed(d) >>> n);
        else         return d >> n;
    endfunction

    function automatic int unsigned ref_lat(input logic [SHW-1:0] n);
        int unsigned nn;
        nn = n;
`ifdef SPU32_SEQSHIFTER_STEP4_EN
        return nn / 4 + nn % 4 + 1;
`else
        return nn + 1;
`endif
    endfunction

    task automatic check32(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request for one cycle starting at the current negedge; returns at
    // the negedge right after the accepting edge with operands scrambled.
    task automatic issue(input logic [XLEN-1:0] d, input logic [SHW-1:0] n, input logic se, input logic l);
        exp_t e;
        stb   = 1'b1;
        din   = d;
        shamt = n;
        sext  = se;
        lsh   = l;
        e.data = ref_shift(d, n, se, l);
        e.lat  = ref_lat(n);
        sb.push_back(e);
        @(negedge clk);
        stb   = 1'b0;
        din   = $urandom;
        shamt = SHW'($urandom_range(0, 31));
        sext  = 1'($urandom_range(0, 1));
        lsh   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ack(input string tag, input int unsigned start_lat);
        int unsigned lat;
        exp_t        e;
        lat = start_lat;
        while (ack !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        assert (ack === 1'b1) else begin
            errors++;
            $error("FAIL %s_timeout: observed=no ack expected=ack within 100 cycles", tag);
        end
        if (ack === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL %s_unexpected_ack: observed=ack expected=no pending request", tag);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check32({tag, "_data"}, dout, e.data);
                check32({tag, "_latency"}, XLEN'(lat), XLEN'(e.lat));
            end
        end
    endtask

    initial begin
        int acks;
        logic [XLEN-1:0] rd;
        logic [SHW-1:0]  rn;

        rst   = 1'b1;
        stb   = 1'b0;
        din   = '0;
        shamt = '0;
        sext  = 1'b0;
        lsh   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state and no spontaneous ack.
        check32("reset_busy", {31'b0, busy}, 32'd0);
        check32("reset_ack", {31'b0, ack}, 32'd0);
        check32("reset_data", dout, 32'd0);
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        check32("idle_no_ack", XLEN'(acks), 32'd0);

        // SRL by 31; then confirm pulse width and held result.
        issue(32'h8000_0000, 5'd31, 1'b0, 1'b0);
        check32("busy_after_accept", {31'b0, busy}, 32'd1);
        wait_ack("srl31", 0);
        check32("srl31_not_busy_at_ack", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check32("srl31_ack_one_cycle", {31'b0, ack}, 32'd0);
        check32("srl31_data_held", dout, 32'h0000_0001);

        // SRA, left shift ignoring sign extension, plain SLL.
        issue(32'hF000_0000, 5'd4, 1'b1, 1'b0);
        wait_ack("sra4", 0);
        issue(32'hF000_0000, 5'd4, 1'b1, 1'b1);
        wait_ack("sll4_sext", 0);
        issue(32'h0000_0001, 5'd4, 1'b0, 1'b1);
        wait_ack("sll4", 0);
        issue(32'h8765_4321, 5'd13, 1'b1, 1'b0);
        wait_ack("sra13", 0);

        // Zero shift followed by a request in the ack cycle.
        @(negedge clk);
        issue(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
        wait_ack("zero", 0);
        issue(32'h0000_0001, 5'd1, 1'b0, 1'b1);
        wait_ack("b2b", 0);

        // Request while busy is ignored.
        issue(32'hA5A5_0000, 5'd20, 1'b0, 1'b0);
        stb   = 1'b1;
        din   = 32'h1234_5678;
        shamt = 5'd1;
        lsh   = 1'b1;
        @(negedge clk);
        check32("busy_ignored", {31'b0, busy}, 32'd1);
        stb = 1'b0;
        @(negedge clk);
        wait_ack("busy_first", 2);
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        check32("busy_no_second_ack", XLEN'(acks), 32'd0);

        // Reset in the middle of a shift discards it.
        issue(32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check32("abort_busy", {31'b0, busy}, 32'd0);
        check32("abort_ack", {31'b0, ack}, 32'd0);
        check32("abort_data", dout, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (40) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        check32("abort_no_ack", XLEN'(acks), 32'd0);
        issue(32'h0F0F_0F0F, 5'd7, 1'b0, 1'b1);
        wait_ack("after_abort", 0);

        // Random operations, sometimes back-to-back, sometimes with gaps.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            rd = $urandom;
            rn = SHW'($urandom_range(0, 31));
            issue(rd, rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_ack("rand", 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
